// File: rtl/trdb_trace_ctrl.sv
// trdb_trace_ctrl: start -> trace -> stop -> drain sequencing for the trace encoder enable path.
// Build option: define TRDB_RESYNC_EN to include the periodic RESYNC sync-packet logic.
module trdb_trace_ctrl #(
  parameter int unsigned RESYNC_W      = 16,
  parameter int unsigned RESYNC_MAX    = 4096,
  parameter int unsigned DRAIN_TIMEOUT = 64,
  parameter int unsigned LOSSLESS      = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       trace_req_on_i,
  input  logic       trace_req_off_i,
  input  logic       encapsulator_ready_i,
  input  logic       iretire_i,
  input  logic       sync_ack_i,
  output logic       sync_req_o,
  output logic [1:0] sync_kind_o,
  output logic       trace_enable_o,
  output logic       stall_core_o,
  output logic       overflow_o,
  output logic [2:0] state_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_TRACE = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam logic [1:0] KIND_START  = 2'd0;
  localparam logic [1:0] KIND_RESYNC = 2'd1;
  localparam logic [1:0] KIND_STOP   = 2'd2;

  localparam int unsigned        DRAIN_W    = $clog2(DRAIN_TIMEOUT) + 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);

  if ((RESYNC_MAX < 2) || ((RESYNC_MAX >> RESYNC_W) != 0)) begin : g_bad_resync_max
    $error("trdb_trace_ctrl: RESYNC_MAX outside 2..2^RESYNC_W-1");
  end

  logic [2:0]         state_q, state_d;
  logic               sync_req_q, sync_req_d;
  logic [1:0]         sync_kind_q, sync_kind_d;
  logic               trace_enable_q, trace_enable_d;
  logic               overflow_q, overflow_d;
  logic               pend_off_q, pend_off_d;
  logic               on_prev_q, on_prev_d;
  logic               off_prev_q, off_prev_d;
  logic               armed_q, armed_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;

  logic rise_on_s;
  logic rise_off_s;
  logic lossy_bp_s;
  logic rs_pend_s;
  logic rs_pend_nx_s;

  // armed_q suppresses a false edge on the first cycle after reset when a request is already high.
  assign rise_on_s  = trace_req_on_i & ~on_prev_q & armed_q;
  assign rise_off_s = trace_req_off_i & ~off_prev_q & armed_q;
  assign lossy_bp_s = (LOSSLESS == 0) ? ~encapsulator_ready_i : 1'b0;

  assign stall_core_o   = ((LOSSLESS != 0) && (state_q == ST_TRACE)) ? ~encapsulator_ready_i : 1'b0;
  assign sync_req_o     = sync_req_q;
  assign sync_kind_o    = sync_kind_q;
  assign trace_enable_o = trace_enable_q;
  assign overflow_o     = overflow_q;
  assign state_o        = state_q;

`ifdef TRDB_RESYNC_EN
  localparam logic [RESYNC_W-1:0] RESYNC_LAST = RESYNC_W'(RESYNC_MAX - 1);

  logic [RESYNC_W-1:0] rcnt_q, rcnt_d;
  logic                rs_pend_q, rs_pend_d;

  assign rs_pend_s    = rs_pend_q;
  assign rs_pend_nx_s = rs_pend_d;

  // Retirement counter; saturates at RESYNC_LAST and holds a RESYNC request until it is acked.
  always_comb begin
    rcnt_d    = rcnt_q;
    rs_pend_d = rs_pend_q;
    if ((state_q != ST_TRACE) || (state_d != ST_TRACE)) begin
      rcnt_d    = {RESYNC_W{1'b0}};
      rs_pend_d = 1'b0;
    end else if (rs_pend_q) begin
      if (sync_ack_i) begin
        rcnt_d    = {RESYNC_W{1'b0}};
        rs_pend_d = 1'b0;
      end else begin
        rs_pend_d = 1'b1;
      end
    end else if (iretire_i) begin
      if (rcnt_q == RESYNC_LAST) begin
        rs_pend_d = 1'b1;
      end else begin
        rcnt_d = rcnt_q + RESYNC_W'(1);
      end
    end else begin
      rcnt_d = rcnt_q;
    end
  end

  // Resync counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rcnt_q    <= {RESYNC_W{1'b0}};
      rs_pend_q <= 1'b0;
    end else begin
      rcnt_q    <= rcnt_d;
      rs_pend_q <= rs_pend_d;
    end
  end
`else
  logic unused_iretire_s;

  assign unused_iretire_s = iretire_i;
  assign rs_pend_s        = 1'b0;
  assign rs_pend_nx_s     = 1'b0;
`endif

  // Lifecycle next-state, pending-stop, overflow and drain-timer logic.
  always_comb begin
    state_d     = state_q;
    pend_off_d  = pend_off_q;
    overflow_d  = overflow_q;
    drain_cnt_d = drain_cnt_q;
    on_prev_d   = trace_req_on_i;
    off_prev_d  = trace_req_off_i;
    armed_d     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        pend_off_d = 1'b0;
        if (rise_on_s && !rise_off_s) begin
          state_d    = ST_START;
          overflow_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (sync_ack_i) begin
          state_d    = (pend_off_q || rise_off_s) ? ST_STOP : ST_TRACE;
          pend_off_d = 1'b0;
        end else begin
          pend_off_d = pend_off_q | rise_off_s;
        end
      end
      ST_TRACE: begin
        if (rs_pend_s) begin
          // A RESYNC is in flight: stop reasons are deferred so the request kind stays stable.
          overflow_d = overflow_q | lossy_bp_s;
          if (sync_ack_i) begin
            state_d    = (pend_off_q || rise_off_s || lossy_bp_s) ? ST_STOP : ST_TRACE;
            pend_off_d = 1'b0;
          end else begin
            pend_off_d = pend_off_q | rise_off_s | lossy_bp_s;
          end
        end else if (rise_off_s) begin
          state_d = ST_STOP;
        end else if (lossy_bp_s) begin
          state_d    = ST_STOP;
          overflow_d = 1'b1;
        end else begin
          state_d = ST_TRACE;
        end
      end
      ST_STOP: begin
        if (sync_ack_i) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = {DRAIN_W{1'b0}};
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_DRAIN: begin
        if (encapsulator_ready_i) begin
          state_d = ST_IDLE;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d    = ST_IDLE;
          overflow_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        pend_off_d = 1'b0;
      end
    endcase
  end

  // Output decode from the next state so sync_req/kind/enable come straight from flops.
  always_comb begin
    sync_req_d     = 1'b0;
    sync_kind_d    = KIND_START;
    trace_enable_d = 1'b0;
    case (state_d)
      ST_START: begin
        sync_req_d = 1'b1;
      end
      ST_TRACE: begin
        trace_enable_d = 1'b1;
        if (rs_pend_nx_s) begin
          sync_req_d  = 1'b1;
          sync_kind_d = KIND_RESYNC;
        end else begin
          sync_req_d = 1'b0;
        end
      end
      ST_STOP: begin
        sync_req_d     = 1'b1;
        sync_kind_d    = KIND_STOP;
        trace_enable_d = 1'b1;
      end
      default: begin
        sync_req_d = 1'b0;
      end
    endcase
  end

  // Lifecycle state, edge history and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      sync_req_q     <= 1'b0;
      sync_kind_q    <= 2'd0;
      trace_enable_q <= 1'b0;
      overflow_q     <= 1'b0;
      pend_off_q     <= 1'b0;
      on_prev_q      <= 1'b0;
      off_prev_q     <= 1'b0;
      armed_q        <= 1'b0;
      drain_cnt_q    <= {DRAIN_W{1'b0}};
    end else begin
      state_q        <= state_d;
      sync_req_q     <= sync_req_d;
      sync_kind_q    <= sync_kind_d;
      trace_enable_q <= trace_enable_d;
      overflow_q     <= overflow_d;
      pend_off_q     <= pend_off_d;
      on_prev_q      <= on_prev_d;
      off_prev_q     <= off_prev_d;
      armed_q        <= armed_d;
      drain_cnt_q    <= drain_cnt_d;
    end
  end

endmodule
